// File: rtl/bus_stable_sync_pkg.sv
// Shared constants and elaboration helpers for bus_stable_sync.
// The error-counter width is used only when BUS_STABLE_SYNC_ERRCNT_EN is defined.
package bus_stable_sync_pkg;

    localparam int ERRCNT_WIDTH = 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // A single synchroniser flop is not metastability-safe, and a zero-length window would commit torn words.
    function automatic bit params_ok(input int sync_stages, input int stable_cycles);
        return (sync_stages >= 2) && (stable_cycles >= 1);
    endfunction

endpackage

// File: rtl/bus_stable_sync_if.sv
// Bus bundle for bus_stable_sync: flattened data, hold, commit outputs.
// Optional error-counter signals exist only with BUS_STABLE_SYNC_ERRCNT_EN.
interface bus_stable_sync_if
    import bus_stable_sync_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 2
) ();

    logic [CHANNELS*DATA_WIDTH-1:0] i_a_din;
    logic [CHANNELS-1:0]            i_hold;
    logic [CHANNELS*DATA_WIDTH-1:0] o_d_dout;
    logic [CHANNELS-1:0]            o_update;

`ifdef BUS_STABLE_SYNC_ERRCNT_EN
    logic                             i_err_clr;
    logic [CHANNELS*ERRCNT_WIDTH-1:0] o_err_cnt;

    modport master (
        output i_a_din, i_hold, i_err_clr,
        input  o_d_dout, o_update, o_err_cnt
    );

    modport slave (
        input  i_a_din, i_hold, i_err_clr,
        output o_d_dout, o_update, o_err_cnt
    );
`else
    modport master (
        output i_a_din, i_hold,
        input  o_d_dout, o_update
    );

    modport slave (
        input  i_a_din, i_hold,
        output o_d_dout, o_update
    );
`endif

endinterface

// File: rtl/bus_stable_sync_ch.sv
// One channel: synchroniser, stability qualifier, committed output and update strobe.
// BUS_STABLE_SYNC_ERRCNT_EN adds a saturating abandoned-change counter.
module bus_stable_sync_ch
    import bus_stable_sync_pkg::*;
#(
    parameter int                    DATA_WIDTH      = 16,
    parameter int                    SYNC_STAGES     = 2,
    parameter int                    STABLE_CYCLES   = 4,
    parameter logic [DATA_WIDTH-1:0] OUT_RESET_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   din,
    input  logic                    hold,
`ifdef BUS_STABLE_SYNC_ERRCNT_EN
    input  logic                    err_clr,
    output logic [ERRCNT_WIDTH-1:0] err_cnt,
`endif
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    update
);

    localparam int               CNT_W   = (clog2(STABLE_CYCLES) < 1) ? 1 : clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] s;
    logic [DATA_WIDTH-1:0] p_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  commit;

    assign s      = sync_q[SYNC_STAGES-1];
    assign commit = (cnt_q == CNT_MAX) && (p_q != dout) && !hold;

    // The counter keeps qualifying under hold, so release commits on the very next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= OUT_RESET_VALUE;
            end
            p_q    <= OUT_RESET_VALUE;
            cnt_q  <= '0;
            dout   <= OUT_RESET_VALUE;
            update <= 1'b0;
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            p_q <= s;
            if (s != p_q) begin
                cnt_q <= '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (commit) begin
                dout   <= p_q;
                update <= 1'b1;
            end else begin
                update <= 1'b0;
            end
        end
    end

`ifdef BUS_STABLE_SYNC_ERRCNT_EN
    logic abandon;

    assign abandon = (s != p_q) && (p_q != dout);

    // Clear takes priority over a coincident abandon.
    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            err_cnt <= '0;
        end else if (abandon && (err_cnt != {ERRCNT_WIDTH{1'b1}})) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/bus_stable_sync.sv
// bus_stable_sync top: CHANNELS independent stable-value capture channels, channel-major flattening.
// Define BUS_STABLE_SYNC_ERRCNT_EN to add per-channel abandoned-change counters and a common clear.
module bus_stable_sync
    import bus_stable_sync_pkg::*;
#(
    parameter int                    DATA_WIDTH      = 16,
    parameter int                    CHANNELS        = 2,
    parameter int                    SYNC_STAGES     = 2,
    parameter int                    STABLE_CYCLES   = 4,
    parameter logic [DATA_WIDTH-1:0] OUT_RESET_VALUE = '0
) (
    input logic              i_clk,
    input logic              i_rst,
    bus_stable_sync_if.slave bus
);

    if (!params_ok(SYNC_STAGES, STABLE_CYCLES)) begin : g_bad_params
        $error("bus_stable_sync: SYNC_STAGES must be >= 2 and STABLE_CYCLES >= 1");
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        bus_stable_sync_ch #(
            .DATA_WIDTH      (DATA_WIDTH),
            .SYNC_STAGES     (SYNC_STAGES),
            .STABLE_CYCLES   (STABLE_CYCLES),
            .OUT_RESET_VALUE (OUT_RESET_VALUE)
        ) u_ch (
            .clk     (i_clk),
            .rst     (i_rst),
            .din     (bus.i_a_din[c*DATA_WIDTH +: DATA_WIDTH]),
            .hold    (bus.i_hold[c]),
`ifdef BUS_STABLE_SYNC_ERRCNT_EN
            .err_clr (bus.i_err_clr),
            .err_cnt (bus.o_err_cnt[c*ERRCNT_WIDTH +: ERRCNT_WIDTH]),
`endif
            .dout    (bus.o_d_dout[c*DATA_WIDTH +: DATA_WIDTH]),
            .update  (bus.o_update[c])
        );
    end

endmodule

// File: tb/tb_bus_stable_sync.sv
// Directed self-checking bench for bus_stable_sync at default parameters.
// Error-counter steps are compiled in only with BUS_STABLE_SYNC_ERRCNT_EN.
module tb_bus_stable_sync;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    bus_stable_sync_if #(.DATA_WIDTH(16), .CHANNELS(2)) bus ();

    bus_stable_sync dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] ch0, input logic [15:0] ch1, input logic [1:0] hold);
        bus.i_a_din = {ch1, ch0};
        bus.i_hold  = hold;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
`ifdef BUS_STABLE_SYNC_ERRCNT_EN
        bus.i_err_clr = 1'b0;
`endif
        applyStimulus(16'h0000, 16'h0000, 2'b00);
        tick(3);
        checkOutput("reset_dout", bus.o_d_dout, 32'h0);
        checkOutput("reset_update", {30'h0, bus.o_update}, 32'h0);
`ifdef BUS_STABLE_SYNC_ERRCNT_EN
        checkOutput("reset_errcnt", {16'h0, bus.o_err_cnt}, 32'h0);
`endif
        rst = 1'b0;

        // Input equal to the reset value must never strobe.
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("zero_no_update", {30'h0, bus.o_update}, 32'h0);
        end
        checkOutput("zero_dout", bus.o_d_dout, 32'h0);

        applyStimulus(16'hA5A5, 16'h0000, 2'b00);
        tick(6);
        checkOutput("lat_edge6_update", {30'h0, bus.o_update}, 32'h0);
        checkOutput("lat_edge6_dout", bus.o_d_dout, 32'h0);
        tick();
        checkOutput("lat_edge7_update", {30'h0, bus.o_update}, 32'h1);
        checkOutput("lat_edge7_dout", bus.o_d_dout, 32'h0000_A5A5);
        tick();
        checkOutput("lat_edge8_update", {30'h0, bus.o_update}, 32'h0);
        checkOutput("lat_edge8_dout", bus.o_d_dout, 32'h0000_A5A5);

        applyStimulus(16'hA5A5, 16'h1234, 2'b00);
        tick(3);
        applyStimulus(16'hA5A5, 16'h0000, 2'b00);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("glitch_no_update", {30'h0, bus.o_update}, 32'h0);
        end
        checkOutput("glitch_dout", bus.o_d_dout, 32'h0000_A5A5);
`ifdef BUS_STABLE_SYNC_ERRCNT_EN
        checkOutput("glitch_errcnt", {16'h0, bus.o_err_cnt}, 32'h0000_0100);
`endif

        applyStimulus(16'hA5A5, 16'h1234, 2'b00);
        tick(6);
        checkOutput("steady_edge6_update", {30'h0, bus.o_update}, 32'h0);
        tick();
        checkOutput("steady_edge7_update", {30'h0, bus.o_update}, 32'h2);
        checkOutput("steady_edge7_dout", bus.o_d_dout, 32'h1234_A5A5);
        tick();
        checkOutput("steady_edge8_update", {30'h0, bus.o_update}, 32'h0);

        applyStimulus(16'h00FF, 16'h1234, 2'b01);
        for (int i = 0; i < 20; i++) begin
            tick();
            checkOutput("hold_no_update", {30'h0, bus.o_update}, 32'h0);
        end
        checkOutput("hold_dout", bus.o_d_dout, 32'h1234_A5A5);
        applyStimulus(16'h00FF, 16'h1234, 2'b00);
        tick();
        checkOutput("release_update", {30'h0, bus.o_update}, 32'h1);
        checkOutput("release_dout", bus.o_d_dout, 32'h1234_00FF);
        tick();
        checkOutput("release_single_pulse", {30'h0, bus.o_update}, 32'h0);

        // Reset lands on edge 4 of the 0xBEEF qualification.
        applyStimulus(16'hBEEF, 16'h1234, 2'b00);
        tick(3);
        rst = 1'b1;
        tick();
        checkOutput("midrst_dout", bus.o_d_dout, 32'h0);
        checkOutput("midrst_update", {30'h0, bus.o_update}, 32'h0);
        rst = 1'b0;
        tick(6);
        checkOutput("postrst_edge6_update", {30'h0, bus.o_update}, 32'h0);
        checkOutput("postrst_edge6_dout", bus.o_d_dout, 32'h0);
        tick();
        checkOutput("postrst_edge7_update", {30'h0, bus.o_update}, 32'h3);
        checkOutput("postrst_edge7_dout", bus.o_d_dout, 32'h1234_BEEF);
        tick();
        checkOutput("postrst_edge8_update", {30'h0, bus.o_update}, 32'h0);

`ifdef BUS_STABLE_SYNC_ERRCNT_EN
        checkOutput("postrst_errcnt", {16'h0, bus.o_err_cnt}, 32'h0);
        // Alternating every cycle: every edge sees s != p with p != committed 0x1234.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(16'hBEEF, (i % 2 == 0) ? 16'h5555 : 16'hAAAA, 2'b00);
            tick();
        end
        checkOutput("errcnt_saturated", {16'h0, bus.o_err_cnt}, 32'h0000_FF00);
        checkOutput("errcnt_dout_kept", bus.o_d_dout, 32'h1234_BEEF);
        applyStimulus(16'hBEEF, 16'h5555, 2'b00);
        bus.i_err_clr = 1'b1;
        tick();
        checkOutput("errclr_wins", {16'h0, bus.o_err_cnt}, 32'h0);
        bus.i_err_clr = 1'b0;
        applyStimulus(16'hBEEF, 16'hAAAA, 2'b00);
        tick();
        checkOutput("errcnt_after_clr", {16'h0, bus.o_err_cnt}, 32'h0000_0100);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
